mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port data RAM (word-addressed, 1-cycle registered read, strobes ld/str/sel) between the instruction-fetch port (read-only) and the load/store port (read/write) of the MIPS core.
- Sequences each RAM access and returns read data to the requester with valid pulses.
- Uses fixed priority with a starvation guard, so fetch always makes progress.

Parameters:
ADDR_W, 10, word-address width of RAM and both ports
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits; then fetch is forced to win

Ports:
clk  in  1  system clock, rising edge
clr  in  1  asynchronous active-low reset (clr=0 resets)
i_req  in  1  fetch read request; level, held until i_gnt
i_addr  in  ADDR_W  fetch word address, stable while i_req=1
i_gnt  out  1  fetch request accepted this cycle
i_rvalid  out  1  one-cycle pulse, i_rdata valid
i_rdata  out  DATA_W  fetch read data, held until next i_rvalid
d_req  in  1  load/store request; level, held until d_gnt
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse, d_rdata valid (loads only)
d_rdata  out  DATA_W  load data, held until next d_rvalid
ram_addr  out  ADDR_W  RAM address
ram_din  out  DATA_W  RAM write data
ram_ld  out  1  RAM read strobe
ram_str  out  1  RAM write strobe
ram_sel  out  1  RAM select, =ram_ld|ram_str
ram_dout  in  DATA_W  RAM read data, valid the cycle after ram_ld
busy  out  1  1 while in RD_WAIT

Behaviour:
- Clock and reset: one clock (clk); reset clr is asynchronous, active-low.
- Reset values:
  - state=IDLE, starve_cnt=0.
  - i_rvalid=d_rvalid=0, i_rdata=d_rdata=0, busy=0.
  - i_gnt=d_gnt=0, and all ram_* strobes 0.
- FSM states: IDLE, RD_WAIT.
- IDLE, with any request pending:
  - Pick a winner. Data wins, except when starve_cnt==STARVE_LIMIT and i_req=1; then fetch wins.
  - In the same cycle (combinational from state and req), drive ram_addr, ram_din, ram_ld/ram_str and ram_sel from the winner, and assert the winner's gnt for exactly 1 cycle.
  - Store (d_we=1): ram_str=1, ram_din=d_wdata, stay IDLE. Back-to-back stores run 1 per cycle.
  - Read (fetch, or load with d_we=0): ram_ld=1, record the owner, next state RD_WAIT.
- RD_WAIT:
  - No grant; RAM strobes 0; busy=1.
  - Capture ram_dout into the owner's rdata register and return to IDLE.
  - The owner's rvalid is 1 in the next cycle. That cycle is IDLE, so a new grant may be issued in it.
- Read latency: grant in cycle N, rvalid/rdata in cycle N+2. Read throughput is 1 per 2 cycles.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) on each d_gnt while i_req=1.
  - It clears to 0 on i_gnt, or in any cycle with i_req=0.
- Idle cycle: no request means all strobes 0 and no state change.
- Requester changes inputs before its grant: the current input values are used; the arbiter does not latch ungranted inputs.
- Reset mid-operation: clr=0 in RD_WAIT aborts the read; no rvalid is ever produced for it.
- rdata is not cleared between accesses; only the rvalid pulse qualifies it.
- Address width: ram_addr = selected address, no translation; all 2^ADDR_W words are legal.

Decomposition:
- Shared definitions file mem_arb_defs: state encodings (IDLE=1'b0, RD_WAIT=1'b1) and owner IDs (OWN_I=1'b0, OWN_D=1'b1).
- One sub-module, arb_pick: combinational winner select plus the starve_cnt register.
- The top level holds the FSM, RAM drive and the return-data registers.

Test Plan:
- Fetch alone, i_addr=0x010 with RAM[0x010]=0xDEADBEEF → i_gnt in cycle N, ram_ld=1 with ram_addr=0x010; i_rvalid=1 and i_rdata=0xDEADBEEF in N+2.
- Store then load, d_addr=0x3FF, d_wdata=0x12345678 → store granted in 1 cycle with ram_str=1 and ram_sel=1; the following load returns d_rdata=0x12345678 two cycles after its grant.
- Simultaneous requests from IDLE, both reads → d_gnt first, i_gnt 2 cycles later; both rvalids arrive in grant order.
- Continuous data stores with i_req held, STARVE_LIMIT=4 → exactly 4 d_gnt, then i_gnt on the 5th grant slot; starve_cnt returns to 0.
- Load granted, then clr=0 pulsed in RD_WAIT → state=IDLE and d_rvalid never asserts; after clr=1 a new fetch completes normally.
- No requests for 10 cycles → ram_ld=ram_str=ram_sel=0, both gnt=0, busy=0 throughout.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM port arbiter:
// FSM state encodings, read-owner IDs and a counter-width helper.
package mem_port_arbiter_pkg;

   // Arbiter FSM states
   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_e;

   // Requester that owns the read currently in flight
   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   // Bits needed to hold a counter value in the range 0..limit (never below 1)
   function automatic int unsigned cnt_width(input int unsigned limit);
      int unsigned w;
      w = $clog2(limit + 32'd1);
      if (w < 32'd1) begin
         w = 32'd1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Winner selection for the shared RAM port. Data has fixed priority over
// fetch, except when fetch has waited through STARVE_LIMIT data grants, in
// which case fetch is forced to win. Also owns the starvation counter.
module mem_port_arbiter_arb_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic clr,
   input  logic grant_en_i,
   input  logic i_req_i,
   input  logic d_req_i,
   output logic i_gnt_o,
   output logic d_gnt_o
);

   localparam int unsigned CW = cnt_width(STARVE_LIMIT);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_cnt_q;
   logic [CW-1:0] starve_cnt_d;
   logic          force_i;

   // Winner select: grants only when the FSM can accept a new access
   always_comb begin
      force_i = (starve_cnt_q == LIMIT);
      i_gnt_o = 1'b0;
      d_gnt_o = 1'b0;
      if (grant_en_i) begin
         if (i_req_i && (force_i || !d_req_i)) begin
            i_gnt_o = 1'b1;
         end else if (d_req_i) begin
            d_gnt_o = 1'b1;
         end else begin
            i_gnt_o = 1'b0;
         end
      end else begin
         i_gnt_o = 1'b0;
      end
   end

   // Starvation counter next value: counts data grants while fetch waits
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!i_req_i || i_gnt_o) begin
         starve_cnt_d = '0;
      end else if (d_gnt_o && (starve_cnt_q != LIMIT)) begin
         starve_cnt_d = starve_cnt_q + CW'(1);
      end else begin
         starve_cnt_d = starve_cnt_q;
      end
   end

   // Starvation counter register
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         starve_cnt_q <= '0;
      end else begin
         starve_cnt_q <= starve_cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data RAM (1-cycle registered read) between the
// read-only instruction-fetch port and the load/store port. Stores finish
// in the grant cycle; reads go through RD_WAIT and return data with an
// rvalid pulse two cycles after the grant.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_ld,
   output logic              ram_str,
   output logic              ram_sel,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy
);

   state_e            state_q, state_d;
   owner_e            owner_q, owner_d;
   logic              i_rvalid_q, i_rvalid_d;
   logic              d_rvalid_q, d_rvalid_d;
   logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              i_gnt_s, d_gnt_s;

   mem_port_arbiter_arb_pick #(
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .clk        (clk),
      .clr        (clr),
      .grant_en_i (state_q == IDLE),
      .i_req_i    (i_req),
      .d_req_i    (d_req),
      .i_gnt_o    (i_gnt_s),
      .d_gnt_o    (d_gnt_s)
   );

   // FSM state and read-owner registers
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= IDLE;
         owner_q <= OWN_I;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
      end
   end

   // FSM next state: any granted read moves to RD_WAIT, stores stay in IDLE
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
         IDLE: begin
            if (i_gnt_s) begin
               state_d = RD_WAIT;
               owner_d = OWN_I;
            end else if (d_gnt_s && !d_we) begin
               state_d = RD_WAIT;
               owner_d = OWN_D;
            end else begin
               state_d = IDLE;
            end
         end
         RD_WAIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM outputs: RAM drive from the winner in IDLE, nothing in RD_WAIT
   always_comb begin
      ram_addr = '0;
      ram_din  = '0;
      ram_ld   = 1'b0;
      ram_str  = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_gnt_s) begin
               ram_addr = i_addr;
               ram_ld   = 1'b1;
            end else if (d_gnt_s) begin
               ram_addr = d_addr;
               if (d_we) begin
                  ram_din = d_wdata;
                  ram_str = 1'b1;
               end else begin
                  ram_ld = 1'b1;
               end
            end else begin
               ram_addr = '0;
            end
         end
         RD_WAIT: begin
            ram_addr = '0;
         end
         default: begin
            ram_addr = '0;
         end
      endcase
   end

   // Return-data capture: RAM data is valid in RD_WAIT, pulse rvalid next cycle
   always_comb begin
      i_rvalid_d = 1'b0;
      d_rvalid_d = 1'b0;
      i_rdata_d  = i_rdata_q;
      d_rdata_d  = d_rdata_q;
      if (state_q == RD_WAIT) begin
         if (owner_q == OWN_I) begin
            i_rvalid_d = 1'b1;
            i_rdata_d  = ram_dout;
         end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = ram_dout;
         end
      end else begin
         i_rvalid_d = 1'b0;
      end
   end

   // Return-data registers; rdata holds until the next read for that port
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         i_rvalid_q <= i_rvalid_d;
         d_rvalid_q <= d_rvalid_d;
         i_rdata_q  <= i_rdata_d;
         d_rdata_q  <= d_rdata_d;
      end
   end

   assign i_gnt    = i_gnt_s;
   assign d_gnt    = d_gnt_s;
   assign ram_sel  = ram_ld | ram_str;
   assign busy     = (state_q == RD_WAIT);
   assign i_rvalid = i_rvalid_q;
   assign d_rvalid = d_rvalid_q;
   assign i_rdata  = i_rdata_q;
   assign d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for the
// basic fetch/store/load/collision flow, plus hand-written sequences for
// starvation, mid-read reset and a long idle stretch.
module tb_mem_port_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk;
   logic          clr;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic          i_gnt, i_rvalid;
   logic [DW-1:0] i_rdata;
   logic          d_req, d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt, d_rvalid;
   logic [DW-1:0] d_rdata;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_ld, ram_str, ram_sel;
   logic [DW-1:0] ram_dout;
   logic          busy;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
      .clk(clk), .clr(clr),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .ram_addr(ram_addr), .ram_din(ram_din), .ram_ld(ram_ld), .ram_str(ram_str),
      .ram_sel(ram_sel), .ram_dout(ram_dout), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: synchronous write, 1-cycle registered read
   always @(posedge clk) begin
      if (ram_str) mem[ram_addr] <= ram_din;
      if (ram_ld)  ram_dout <= mem[ram_addr];
   end

   typedef struct {
      logic          i_req;
      logic [AW-1:0] i_addr;
      logic          d_req;
      logic          d_we;
      logic [AW-1:0] d_addr;
      logic [DW-1:0] d_wdata;
      logic          e_igt, e_dgt, e_ld, e_str, e_sel;
      logic [AW-1:0] e_addr;
      logic          e_busy, e_irv, e_drv;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ir, input logic [AW-1:0] ia, input logic dr,
                        input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
      i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
   endtask

   function automatic vec_t mk(input logic ir, input logic [AW-1:0] ia, input logic dr,
                               input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                               input logic igt, input logic dgt, input logic ld, input logic st,
                               input logic [AW-1:0] ea, input logic bz, input logic irv,
                               input logic drv);
      vec_t v;
      v.i_req = ir; v.i_addr = ia; v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
      v.e_igt = igt; v.e_dgt = dgt; v.e_ld = ld; v.e_str = st; v.e_sel = ld | st;
      v.e_addr = ea; v.e_busy = bz; v.e_irv = irv; v.e_drv = drv;
      return v;
   endfunction

   initial begin
      int dcnt;
      int slot;
      bit seen;

      for (int a = 0; a < (1<<AW); a++) mem[a] = 32'h0;
      mem[10'h010] = 32'hDEADBEEF;
      mem[10'h020] = 32'hA5A50020;
      mem[10'h030] = 32'h5A5A0030;
      mem[10'h040] = 32'hCAFEF00D;
      mem[10'h050] = 32'h0BADF00D;
      ram_dout = 32'h0;

      //            ireq iaddr   dreq we   daddr   wdata          igt  dgt  ld   str  addr    busy irv  drv
      vecs[0]  = mk(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0,        1'b0,1'b0,1'b0,1'b0,10'h000,1'b0,1'b0,1'b0);
      vecs[1]  = mk(1'b1, 10'h010, 1'b0, 1'b0, 10'h000, 32'h0,        1'b1,1'b0,1'b1,1'b0,10'h010,1'b0,1'b0,1'b0);
      vecs[2]  = mk(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0,        1'b0,1'b0,1'b0,1'b0,10'h000,1'b1,1'b0,1'b0);
      vecs[3]  = mk(1'b0, 10'h000, 1'b1, 1'b1, 10'h3FF, 32'h12345678, 1'b0,1'b1,1'b0,1'b1,10'h3FF,1'b0,1'b1,1'b0);
      vecs[4]  = mk(1'b0, 10'h000, 1'b1, 1'b0, 10'h3FF, 32'h0,        1'b0,1'b1,1'b1,1'b0,10'h3FF,1'b0,1'b0,1'b0);
      vecs[5]  = mk(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0,        1'b0,1'b0,1'b0,1'b0,10'h000,1'b1,1'b0,1'b0);
      vecs[6]  = mk(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0,        1'b0,1'b0,1'b0,1'b0,10'h000,1'b0,1'b0,1'b1);
      vecs[7]  = mk(1'b1, 10'h020, 1'b1, 1'b0, 10'h030, 32'h0,        1'b0,1'b1,1'b1,1'b0,10'h030,1'b0,1'b0,1'b0);
      vecs[8]  = mk(1'b1, 10'h020, 1'b0, 1'b0, 10'h000, 32'h0,        1'b0,1'b0,1'b0,1'b0,10'h000,1'b1,1'b0,1'b0);
      vecs[9]  = mk(1'b1, 10'h020, 1'b0, 1'b0, 10'h000, 32'h0,        1'b1,1'b0,1'b1,1'b0,10'h020,1'b0,1'b0,1'b1);
      vecs[10] = mk(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0,        1'b0,1'b0,1'b0,1'b0,10'h000,1'b1,1'b0,1'b0);
      vecs[11] = mk(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 32'h0,        1'b0,1'b0,1'b0,1'b0,10'h000,1'b0,1'b1,1'b0);

      // Reset state
      clr = 1'b0;
      drive(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0);
      #12;
      chk("rst_i_gnt", {31'b0, i_gnt}, 32'd0);
      chk("rst_d_gnt", {31'b0, d_gnt}, 32'd0);
      chk("rst_sel", {31'b0, ram_sel}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_rvalid", {30'b0, i_rvalid, d_rvalid}, 32'd0);
      chk("rst_i_rdata", i_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      @(negedge clk);
      clr = 1'b1;

      // Table-driven per-cycle vectors
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         drive(vecs[k].i_req, vecs[k].i_addr, vecs[k].d_req, vecs[k].d_we,
               vecs[k].d_addr, vecs[k].d_wdata);
         #1;
         chk($sformatf("v%0d_i_gnt", k), {31'b0, i_gnt}, {31'b0, vecs[k].e_igt});
         chk($sformatf("v%0d_d_gnt", k), {31'b0, d_gnt}, {31'b0, vecs[k].e_dgt});
         chk($sformatf("v%0d_ram_ld", k), {31'b0, ram_ld}, {31'b0, vecs[k].e_ld});
         chk($sformatf("v%0d_ram_str", k), {31'b0, ram_str}, {31'b0, vecs[k].e_str});
         chk($sformatf("v%0d_ram_sel", k), {31'b0, ram_sel}, {31'b0, vecs[k].e_sel});
         chk($sformatf("v%0d_ram_addr", k), {22'b0, ram_addr}, {22'b0, vecs[k].e_addr});
         chk($sformatf("v%0d_busy", k), {31'b0, busy}, {31'b0, vecs[k].e_busy});
         chk($sformatf("v%0d_i_rvalid", k), {31'b0, i_rvalid}, {31'b0, vecs[k].e_irv});
         chk($sformatf("v%0d_d_rvalid", k), {31'b0, d_rvalid}, {31'b0, vecs[k].e_drv});
         if (k == 3) chk("v3_ram_din", ram_din, 32'h12345678);
         if (k == 3) chk("v3_i_rdata", i_rdata, 32'hDEADBEEF);
         if (k == 6) chk("v6_d_rdata", d_rdata, 32'h12345678);
         if (k == 9) chk("v9_d_rdata", d_rdata, 32'h5A5A0030);
         if (k == 11) chk("v11_i_rdata", i_rdata, 32'hA5A50020);
      end
      chk("held_d_rdata", d_rdata, 32'h5A5A0030);

      // Starvation: back-to-back stores while fetch waits
      dcnt = 0; slot = 0; seen = 1'b0;
      for (int k = 1; k <= 12 && !seen; k++) begin
         @(negedge clk);
         drive(1'b1, 10'h040, 1'b1, 1'b1, 10'(10'h100 + k), 32'(k));
         #1;
         if (d_gnt) dcnt++;
         if (i_gnt) begin
            seen = 1'b1;
            slot = k;
            chk("starve_i_addr", {22'b0, ram_addr}, {22'b0, 10'h040});
         end
      end
      chk("starve_seen_i_gnt", {31'b0, seen}, 32'd1);
      chk("starve_d_gnts", dcnt, 32'd4);
      chk("starve_slot", slot, 32'd5);
      @(negedge clk);
      drive(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0);
      #1;
      chk("starve_cnt_clear", 32'(dut.u_pick.starve_cnt_q), 32'd0);
      chk("starve_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
      #1;
      chk("starve_i_rvalid", {31'b0, i_rvalid}, 32'd1);
      chk("starve_i_rdata", i_rdata, 32'hCAFEF00D);
      chk("starve_store_mem", mem[10'h104], 32'd4);

      // Reset during RD_WAIT aborts the load
      @(negedge clk);
      drive(1'b0, 10'h0, 1'b1, 1'b0, 10'h050, 32'h0);
      #1;
      chk("abort_d_gnt", {31'b0, d_gnt}, 32'd1);
      @(negedge clk);
      drive(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0);
      #1;
      chk("abort_busy_pre", {31'b0, busy}, 32'd1);
      #1;
      clr = 1'b0;
      #1;
      chk("abort_busy_rst", {31'b0, busy}, 32'd0);
      @(negedge clk);
      clr = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         #1;
         if (d_rvalid) seen = 1'b1;
      end
      chk("abort_no_d_rvalid", {31'b0, seen}, 32'd0);
      chk("abort_d_rdata", d_rdata, 32'd0);

      // Fetch after reset completes normally
      @(negedge clk);
      drive(1'b1, 10'h010, 1'b0, 1'b0, 10'h0, 32'h0);
      #1;
      chk("post_i_gnt", {31'b0, i_gnt}, 32'd1);
      @(negedge clk);
      drive(1'b0, 10'h0, 1'b0, 1'b0, 10'h0, 32'h0);
      @(negedge clk);
      #1;
      chk("post_i_rvalid", {31'b0, i_rvalid}, 32'd1);
      chk("post_i_rdata", i_rdata, 32'hDEADBEEF);

      // Ten idle cycles: nothing moves
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         chk($sformatf("idle%0d_strobes", k),
             {27'b0, ram_ld, ram_str, ram_sel, i_gnt, d_gnt}, 32'd0);
         chk($sformatf("idle%0d_busy", k), {31'b0, busy}, 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
